rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter.sv | 83 ++++++++
 tb/tb_rf_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin EXU/LSU writeback arbiter with busy scoreboard; define RF_WB_BYPASS_EN for writeback forwarding
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_valid,
  input  logic                  iss_rd_en,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] iss_rs1,
  input  logic [ADDR_WIDTH-1:0] iss_rs2,
  output logic                  iss_stall,
`ifdef RF_WB_BYPASS_EN
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);
  logic [2**ADDR_WIDTH-1:0] busy, busy_nxt;
  logic ptr, hit1, hit2, reserve;
`ifdef RF_WB_BYPASS_EN
  assign fwd1_hit = hit1;
  assign fwd2_hit = hit2;
  assign fwd_data = wdata;
`endif
  // grant: single requester wins outright, ptr breaks ties; nothing granted in reset
  always_comb begin
    exu_ready = rst_n && exu_valid && (!lsu_valid || !ptr);
    lsu_ready = rst_n && lsu_valid && !exu_ready;
  end
  // hazard detection and next busy bitmap; a same-cycle reserve overrides the release
  always_comb begin
`ifdef RF_WB_BYPASS_EN
    hit1 = wen && waddr == iss_rs1 && iss_rs1 != '0;
    hit2 = wen && waddr == iss_rs2 && iss_rs2 != '0;
`else
    hit1 = 1'b0;
    hit2 = 1'b0;
`endif
    iss_stall = iss_valid && ((busy[iss_rs1] && !hit1) || (busy[iss_rs2] && !hit2) || (iss_rd_en && busy[iss_rd]));
    reserve = iss_valid && !iss_stall && iss_rd_en && iss_rd != '0;
    busy_nxt = busy;
    if (wen) busy_nxt[waddr] = 1'b0;
    if (reserve) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  // register the granted write, flip the pointer away from the winner, update busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
      wen <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      wen <= 1'b0;
      if (exu_ready) begin
        ptr <= 1'b1;
        wen <= exu_rd != '0;
        waddr <= exu_rd;
        wdata <= exu_data;
      end else if (lsu_ready) begin
        ptr <= 1'b0;
        wen <= lsu_rd != '0;
        waddr <= lsu_rd;
        wdata <= lsu_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] exu_rd, lsu_rd, iss_rd, iss_rs1, iss_rs2, waddr;
  logic [DW-1:0] exu_data, lsu_data, wdata;
  logic iss_valid, iss_rd_en, iss_stall, wen;
`ifdef RF_WB_BYPASS_EN
  logic fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd_data;
`endif
  int cnt = 0;
  int errs = 0;
  logic [AW+DW:0] sbq[$];
  logic [2**AW-1:0] m_busy = '0, n_busy = '0;
  logic m_ptr = 1'b0, n_ptr = 1'b0;
  logic m_wen = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
`ifdef RF_WB_BYPASS_EN
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
`endif
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic idle();
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd_en = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
  endtask

  // settle inputs, compare combinational outputs with the model, push the expected write
  task automatic pre();
    logic ge, gl, st, h1, h2;
    #1;
    ge = rst_n && exu_valid && (!lsu_valid || !m_ptr);
    gl = rst_n && lsu_valid && (!exu_valid || m_ptr);
`ifdef RF_WB_BYPASS_EN
    h1 = m_wen && m_waddr == iss_rs1 && iss_rs1 != 0;
    h2 = m_wen && m_waddr == iss_rs2 && iss_rs2 != 0;
    cnt++;
    if (fwd1_hit !== h1 || fwd2_hit !== h2) begin
      errs++;
      $display("FAIL fwd_hit: got %b%b expected %b%b", fwd1_hit, fwd2_hit, h1, h2);
    end
`else
    h1 = 1'b0;
    h2 = 1'b0;
`endif
    st = iss_valid && ((m_busy[iss_rs1] && !h1) || (m_busy[iss_rs2] && !h2) || (iss_rd_en && m_busy[iss_rd]));
    cnt++;
    if (exu_ready !== ge || lsu_ready !== gl) begin
      errs++;
      $display("FAIL ready: got exu=%b lsu=%b expected exu=%b lsu=%b", exu_ready, lsu_ready, ge, gl);
    end
    cnt++;
    if (iss_stall !== st) begin
      errs++;
      $display("FAIL iss_stall: got %b expected %b (rs1=%0d rs2=%0d rd=%0d)", iss_stall, st, iss_rs1, iss_rs2, iss_rd);
    end
    if (!rst_n) begin
      n_busy = '0;
      n_ptr = 1'b0;
      sbq.push_back('0);
    end else begin
      n_busy = m_busy;
      n_ptr = m_ptr;
      if (m_wen) n_busy[m_waddr] = 1'b0;
      if (iss_valid && !st && iss_rd_en && iss_rd != 0) n_busy[iss_rd] = 1'b1;
      n_busy[0] = 1'b0;
      if (ge) begin
        n_ptr = 1'b1;
        sbq.push_back({exu_rd != 0, exu_rd, exu_data});
      end else if (gl) begin
        n_ptr = 1'b0;
        sbq.push_back({lsu_rd != 0, lsu_rd, lsu_data});
      end else
        sbq.push_back({1'b0, m_waddr, m_wdata});
    end
  endtask

  // clock edge, pop the expected write and compare the registered outputs
  task automatic post();
    logic [AW+DW:0] e;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    cnt++;
    if ({wen, waddr, wdata} !== e) begin
      errs++;
      $display("FAIL writeback: got wen=%b waddr=%0d wdata=%h expected wen=%b waddr=%0d wdata=%h",
               wen, waddr, wdata, e[AW+DW], e[AW+DW-1:DW], e[DW-1:0]);
    end
    {m_wen, m_waddr, m_wdata} = e;
    m_busy = n_busy;
    m_ptr = n_ptr;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin pre(); post(); end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    exu_valid = 1'b1; lsu_valid = 1'b1; exu_rd = 5'd3; lsu_rd = 5'd4;
    for (int i = 0; i < 2; i++) begin pre(); post(); end
    cnt++;
    if (wen !== 1'b0 || waddr !== '0 || wdata !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got wen=%b waddr=%0d wdata=%h expected 0 0 0", wen, waddr, wdata);
    end
    rst_n = 1'b1;
    idle();
    iss_valid = 1'b1; iss_rs1 = 5'd3;
    pre();
    cnt++;
    if (iss_stall !== 1'b0 || exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: got stall=%b exu_ready=%b lsu_ready=%b expected 0 0 0", iss_stall, exu_ready, lsu_ready);
    end
    post();
  endtask

  task automatic test_single_exu();
    idle();
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
    pre();
    cnt++;
    if (exu_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %b expected 1", exu_ready); end
    post();
    cnt++;
    if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL single_write: got wen=%b waddr=%0d wdata=%h expected 1 5 deadbeef", wen, waddr, wdata);
    end
    idle();
    pre(); post();
    cnt++;
    if (wen !== 1'b0) begin errs++; $display("FAIL single_wen_drop: got %b expected 0", wen); end
  endtask

  task automatic test_conflict();
    logic [3:0] exp_exu;
    logic [AW-1:0] exp_addr;
    exp_exu = 4'b0101;
    do_reset(1);
    idle();
    exu_valid = 1'b1; exu_rd = 5'd1; lsu_valid = 1'b1; lsu_rd = 5'd2;
    for (int i = 0; i < 4; i++) begin
      exu_data = 32'h100 + i; lsu_data = 32'h200 + i;
      pre();
      cnt++;
      if (exu_ready !== exp_exu[i] || lsu_ready !== !exp_exu[i]) begin
        errs++;
        $display("FAIL conflict_grant%0d: got exu=%b lsu=%b expected exu=%b", i, exu_ready, lsu_ready, exp_exu[i]);
      end
      post();
      exp_addr = exp_exu[i] ? 5'd1 : 5'd2;
      cnt++;
      if (waddr !== exp_addr) begin errs++; $display("FAIL conflict_waddr%0d: got %0d expected %0d", i, waddr, exp_addr); end
    end
    idle();
    pre(); post();
  endtask

  task automatic test_scoreboard();
    do_reset(1);
    idle();
    iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd7;
    pre(); post();
    iss_rd_en = 1'b0; iss_rd = '0; iss_rs1 = 5'd7;
    pre();
    cnt++;
    if (iss_stall !== 1'b1) begin errs++; $display("FAIL raw_stall: got %b expected 1", iss_stall); end
    post();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0BADF00D;
    pre();
    cnt++;
    if (iss_stall !== 1'b1 || lsu_ready !== 1'b1) begin
      errs++;
      $display("FAIL stall_cycle_m: got stall=%b lsu_ready=%b expected 1 1", iss_stall, lsu_ready);
    end
    post();
    lsu_valid = 1'b0;
    pre();
`ifdef RF_WB_BYPASS_EN
    cnt++;
    if (iss_stall !== 1'b0 || fwd1_hit !== 1'b1 || fwd_data !== 32'h0BADF00D) begin
      errs++;
      $display("FAIL bypass_m1: got stall=%b hit=%b data=%h expected 0 1 0badf00d", iss_stall, fwd1_hit, fwd_data);
    end
`else
    cnt++;
    if (iss_stall !== 1'b1) begin errs++; $display("FAIL stall_m1: got %b expected 1", iss_stall); end
`endif
    post();
    pre();
    cnt++;
    if (iss_stall !== 1'b0) begin errs++; $display("FAIL stall_m2: got %b expected 0", iss_stall); end
    post();
    idle();
  endtask

  task automatic test_x0_and_set_clear();
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF0000;
    pre();
    cnt++;
    if (lsu_ready !== 1'b1) begin errs++; $display("FAIL x0_ready: got %b expected 1", lsu_ready); end
    post();
    cnt++;
    if (wen !== 1'b0) begin errs++; $display("FAIL x0_wen: got %b expected 0", wen); end
    idle();
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
    pre(); post();
    idle();
    iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd9;
    pre();
    cnt++;
    if (wen !== 1'b1 || waddr !== 5'd9 || iss_stall !== 1'b0) begin
      errs++;
      $display("FAIL setclr_setup: got wen=%b waddr=%0d stall=%b expected 1 9 0", wen, waddr, iss_stall);
    end
    post();
    idle();
    iss_valid = 1'b1; iss_rs1 = 5'd9;
    pre();
    cnt++;
    if (iss_stall !== 1'b1) begin errs++; $display("FAIL set_wins: got stall=%b expected 1", iss_stall); end
    post();
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset(1);
    idle();
    iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd4;
    pre(); post();
    idle();
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h44;
    iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = 5'd6;
    pre(); post();
    idle();
    rst_n = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h45;
    pre(); post();
    cnt++;
    if (wen !== 1'b0) begin errs++; $display("FAIL midflight_wen: got %b expected 0", wen); end
    rst_n = 1'b1;
    idle();
    iss_valid = 1'b1; iss_rs1 = 5'd4; iss_rs2 = 5'd6;
    pre();
    cnt++;
    if (iss_stall !== 1'b0) begin errs++; $display("FAIL midflight_busy: got stall=%b expected 0", iss_stall); end
    post();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    for (int i = 0; i < 24; i++) begin
      exu_valid = 1'($urandom_range(0, 1)); exu_rd = AW'($urandom); exu_data = $urandom;
      lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = AW'($urandom); lsu_data = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd_en = 1'($urandom_range(0, 1));
      iss_rd = AW'($urandom); iss_rs1 = AW'($urandom); iss_rs2 = AW'($urandom);
      pre(); post();
    end
    idle();
    pre(); post();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_exu();
    test_conflict();
    test_scoreboard();
    test_x0_and_set_clear();
    test_reset_midflight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", cnt, errs);
    $finish;
  end
endmodule
